serial_adder_ctrl: RTL

Bit-serial adder controller. It sequences a single one-bit full-adder cell over WIDTH-bit operands, LSB first, one bit per clock, with a registered carry between bits. Valid/ready handshakes on both sides let it sit between an operand producer and a result consumer. This trades WIDTH cycles of latency for a single full-adder cell of area.

---
 rtl/serial_adder_pkg.sv | 23 ++
 rtl/serial_adder_ctrl_full_adder.sv | 17 +
 rtl/serial_adder_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Holds the controller state encoding, the default operand width and
// the helper that sizes the bit counter from the operand width.
package serial_adder_pkg;

  // Controller phases: waiting for operands, stepping bits, holding a result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SA_WIDTH_DEF = 8;

  // Counter width for the default build; instances size their own via cntWidth
  localparam int SA_CNT_W_DEF = $clog2(SA_WIDTH_DEF);

  // The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice
  function automatic int cntWidth(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full-adder cell, written behaviourally.
// The serial controller reuses this single cell for every bit position.
module full_adder_behavioral (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  // Sum is the parity of the three inputs; carry is their majority
  always_comb begin
    Sum  = A ^ B ^ Cin;
    Cout = (A & B) | (A & Cin) | (B & Cin);
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell is stepped LSB first over
// WIDTH-bit operands, one bit per clock, with the carry held in a flop.
// Operands enter through a valid/ready start handshake and the result leaves
// through a valid/ready done handshake.
// Optional build macro OVERFLOW_FLAG_EN adds the signed overflow output ovf.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int CntW = cntWidth(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] aShift_q;
  logic [WIDTH-1:0] bShift_q;
  logic [WIDTH-1:0] sumShift_q;
  logic             carry_q;
  logic             cout_q;
  logic [CntW-1:0]  bitCnt_q;
`ifdef OVERFLOW_FLAG_EN
  logic             ovf_q;
`endif

  logic             cellSum;
  logic             cellCout;
  logic [WIDTH-1:0] sumShift_d;
  logic             lastBit_d;

  full_adder_behavioral u_cell (
    .A    (aShift_q[0]),
    .B    (bShift_q[0]),
    .Cin  (carry_q),
    .Sum  (cellSum),
    .Cout (cellCout)
  );

  // New sum bits enter from the MSB side so bit 0 lands in place after WIDTH steps
  always_comb begin
    sumShift_d = {cellSum, sumShift_q[WIDTH-1:1]};
    lastBit_d  = (bitCnt_q == LastBit);
  end

  // Controller FSM together with the datapath registers it sequences
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      aShift_q   <= '0;
      bShift_q   <= '0;
      sumShift_q <= '0;
      carry_q    <= 1'b0;
      cout_q     <= 1'b0;
      bitCnt_q   <= '0;
`ifdef OVERFLOW_FLAG_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            aShift_q <= a;
            bShift_q <= b;
            carry_q  <= cin;
            bitCnt_q <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          aShift_q   <= aShift_q >> 1;
          bShift_q   <= bShift_q >> 1;
          sumShift_q <= sumShift_d;
          carry_q    <= cellCout;
          bitCnt_q   <= bitCnt_q + CntW'(1);
          if (lastBit_d) begin
            cout_q  <= cellCout;
`ifdef OVERFLOW_FLAG_EN
            ovf_q   <= carry_q ^ cellCout;
`endif
            state_q <= DONE;
          end
        end
        DONE: begin
          if (done_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Handshake and status flags are plain decodes of the registered state
  always_comb begin
    start_ready = (state_q == IDLE);
    busy        = (state_q != IDLE);
    done_valid  = (state_q == DONE);
    sum         = sumShift_q;
    cout        = cout_q;
`ifdef OVERFLOW_FLAG_EN
    ovf         = ovf_q;
`endif
  end

endmodule
